// File: rtl/neural_layer.sv
// Two-input, two-neuron fully connected layer in signed fixed point.
// Each neuron computes a weighted sum plus bias, saturates it to WIDTH bits and
// applies a hard-sigmoid clamped to [0, 1.0]. Two register stages, one result
// per clock, no back-pressure.
module neural_layer #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] cAA,
  input  logic [WIDTH-1:0] cAB,
  input  logic [WIDTH-1:0] cBA,
  input  logic [WIDTH-1:0] cBB,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  output logic             out_valid,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2
);

  // A product shifted right by FRAC fits in PW bits; two products plus a
  // WIDTH-bit bias need two extra bits of headroom.
  localparam int PW = 2*WIDTH - FRAC;
  localparam int SW = PW + 2;

  localparam logic signed [SW-1:0] SMAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] ONE  = {{(SW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
  localparam logic signed [SW-1:0] HALF = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  // Full-precision signed product, arithmetic shift drops FRAC bits (floor).
  function automatic logic signed [PW-1:0] qmul(input logic signed [WIDTH-1:0] x,
                                                input logic signed [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] full;
    logic signed [2*WIDTH-1:0] shifted;
    full    = x * y;
    shifted = full >>> FRAC;
    return shifted[PW-1:0];
  endfunction

  // Saturate to WIDTH bits, then y = s/4 + 0.5 clamped to [0, 1.0].
  function automatic logic [WIDTH-1:0] hard_sigmoid(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sat;
    logic signed [SW-1:0] y;
    if (s > SMAX)      sat = SMAX;
    else if (s < SMIN) sat = SMIN;
    else               sat = s;
    y = (sat >>> 2) + HALF;
    if (y < 0)         y = '0;
    else if (y > ONE)  y = ONE;
    return y[WIDTH-1:0];
  endfunction

  logic signed [PW-1:0]    p_aa, p_ab, p_ba, p_bb;
  logic signed [WIDTH-1:0] bias1, bias2;
  logic                    valid1;

  logic signed [SW-1:0]    sum1, sum2;
  logic [WIDTH-1:0]        act1, act2;

  // Stage 1: capture the four shifted products, the biases and the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_aa   <= '0;
      p_ab   <= '0;
      p_ba   <= '0;
      p_bb   <= '0;
      bias1  <= '0;
      bias2  <= '0;
      valid1 <= 1'b0;
    end else begin
      valid1 <= in_valid;
      if (in_valid) begin
        p_aa  <= qmul(A, cAA);
        p_ab  <= qmul(A, cAB);
        p_ba  <= qmul(B, cBA);
        p_bb  <= qmul(B, cBB);
        bias1 <= b1;
        bias2 <= b2;
      end
    end
  end

  // Sum each neuron's terms in SW bits and apply saturation plus activation.
  always_comb begin
    sum1 = SW'(p_aa) + SW'(p_ba) + SW'(bias1);
    sum2 = SW'(p_ab) + SW'(p_bb) + SW'(bias2);
    act1 = hard_sigmoid(sum1);
    act2 = hard_sigmoid(sum2);
  end

  // Stage 2: register activations; outputs hold unless a new result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      o1        <= '0;
      o2        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= valid1;
      if (valid1) begin
        o1 <= act1;
        o2 <= act2;
      end
    end
  end

endmodule

// File: tb/tb_neural_layer.sv
// Self-checking bench for neural_layer: directed vectors from the layer's
// numeric examples plus randomized vectors, scored against an arithmetic model.
module tb_neural_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] A, B, cAA, cAB, cBA, cBB, b1, b2;
  logic        out_valid;
  logic [15:0] o1, o2;

  typedef struct {
    int          due;
    logic [15:0] e1;
    logic [15:0] e2;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] held1 = '0;
  logic [15:0] held2 = '0;

  neural_layer #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .cAA(cAA), .cAB(cAB), .cBA(cBA), .cBB(cBB),
    .b1(b1), .b2(b2),
    .out_valid(out_valid), .o1(o1), .o2(o2)
  );

  always #5 clk = ~clk;

  // Mathematical floor of x/d for positive d.
  function automatic longint floor_div(input longint x, input longint d);
    longint r;
    r = ((x % d) + d) % d;
    return (x - r) / d;
  endfunction

  // One neuron from its definition: real-valued Q8.8 arithmetic with floor.
  function automatic logic [15:0] ref_neuron(input logic [15:0] x, input logic [15:0] wx,
                                             input logic [15:0] y, input logic [15:0] wy,
                                             input logic [15:0] bias);
    longint s, act;
    s = floor_div(longint'($signed(x)) * longint'($signed(wx)), 256)
      + floor_div(longint'($signed(y)) * longint'($signed(wy)), 256)
      + longint'($signed(bias));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    act = floor_div(s, 4) + 128;
    if (act < 0)   act = 0;
    if (act > 256) act = 256;
    return 16'(act);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s cycle %0d got %04h expected %04h", tag, cyc, got, want);
    end
  endtask

  // Advance one clock and compare outputs 1ns after the edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      held1 = e.e1;
      held2 = e.e2;
      chk("out_valid_pulse", {15'd0, out_valid}, 16'd1);
    end else begin
      chk("out_valid_idle", {15'd0, out_valid}, 16'd0);
    end
    chk("o1", o1, held1);
    chk("o2", o2, held2);
  endtask

  // Present one operand set for the coming edge and schedule its result.
  task automatic drive(input logic v,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] waa, input logic [15:0] wab,
                       input logic [15:0] wba, input logic [15:0] wbb,
                       input logic [15:0] bb1, input logic [15:0] bb2);
    exp_t e;
    in_valid = v;
    A = a; B = b; cAA = waa; cAB = wab; cBA = wba; cBB = wbb; b1 = bb1; b2 = bb2;
    if (v && !rst) begin
      e.due = cyc + 2;
      e.e1  = ref_neuron(a, waa, b, wba, bb1);
      e.e2  = ref_neuron(a, wab, b, wbb, bb2);
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] rnd16();
    logic [15:0] v;
    if ($urandom_range(0, 2) == 0) v = 16'($urandom);
    else begin
      v = 16'($urandom_range(0, 16'h02FF));
      if ($urandom_range(0, 1) == 1) v = -v;
    end
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    step();
    step();
    // Reset state
    rst = 1'b0;
    step();

    // Zero weights and biases: activation of 0 is 0.5
    drive(1'b1, 16'h0100, 16'h0100, '0, '0, '0, '0, '0, '0);
    step(); idle(); step(); step();
    chk("zero_weights_o1", o1, 16'h0080);
    chk("zero_weights_o2", o2, 16'h0080);

    // Weight sets one at a time
    drive(1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, '0, '0, '0, '0);
    step(); idle(); step(); step();
    chk("wA_o1", o1, 16'h00C0);
    drive(1'b1, 16'h0100, 16'h0100, '0, '0, 16'h0100, 16'h0100, '0, '0);
    step(); idle(); step(); step();
    chk("wB_o2", o2, 16'h00C0);
    drive(1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, '0, '0);
    step(); idle(); step(); step();
    chk("wAll_o1", o1, 16'h0100);
    drive(1'b1, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100, '0, '0);
    step(); idle(); step(); step();
    chk("wNeg_o1", o1, 16'h00BF);
    chk("wNeg_o2", o2, 16'h00BF);

    // Same five sets with bias 1.0, streamed back-to-back
    drive(1'b1, 16'h0100, 16'h0100, '0, '0, '0, '0, 16'h0100, 16'h0100); step();
    drive(1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, '0, '0, 16'h0100, 16'h0100); step();
    chk("stream0_o1", o1, 16'h00C0);
    drive(1'b1, 16'h0100, 16'h0100, '0, '0, 16'h0100, 16'h0100, 16'h0100, 16'h0100); step();
    chk("stream1_o1", o1, 16'h0100);
    drive(1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100); step();
    drive(1'b1, 16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100, 16'h0100); step();
    idle(); step();
    step();
    chk("stream4_o2", o2, 16'h00FF);

    // Clamp low, saturation high, independence
    drive(1'b1, 16'h0100, '0, 16'hFE00, '0, '0, '0, '0, '0);
    step(); idle(); step(); step();
    chk("clamp_low_o1", o1, 16'h0000);
    drive(1'b1, 16'h7FFF, '0, 16'h7FFF, '0, '0, '0, '0, '0);
    step(); idle(); step(); step();
    chk("saturate_o1", o1, 16'h0100);
    drive(1'b1, 16'h0100, 16'h0100, '0, '0, 16'h0100, '0, '0, 16'hFE00);
    step(); idle(); step(); step();
    chk("indep_o1", o1, 16'h00C0);
    chk("indep_o2", o2, 16'h0000);

    // Randomized operands with random gaps in in_valid
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd16(), rnd16(), rnd16(), rnd16(),
            rnd16(), rnd16(), rnd16(), rnd16());
      step();
    end
    idle(); step(); step();

    // Reset with two results in flight (and in_valid high): all discarded
    drive(1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, '0, '0, '0, '0); step();
    drive(1'b1, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, '0, '0);
    rst = 1'b1;
    exp_q.delete();
    held1 = '0;
    held2 = '0;
    step();
    rst = 1'b0;
    idle();
    repeat (4) step();

    // A fresh result, then outputs hold while in_valid stays low
    drive(1'b1, 16'h0100, 16'h0100, 16'h0100, '0, '0, '0, '0, 16'h0100);
    step(); idle();
    A = 16'h7FFF; cAA = 16'h8000;
    repeat (5) step();
    chk("hold_o1", o1, 16'h00C0);
    chk("hold_o2", o2, 16'h00C0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_results count %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
